// File: rtl/uart_cmd_ctrl_if.sv
// Signal bundle between the UART byte stream, the actuator bank and uart_cmd_ctrl.
// slave: the controller side; master: the side that feeds and observes it.
interface uart_cmd_ctrl_if;
   logic [7:0] rx_byte;
   logic       rx_done;
   logic       tx_busy;
   logic [7:0] tx_byte;
   logic       tx_start;
   logic [1:0] act_addr;
   logic [7:0] act_data;
   logic       act_wr;
   logic [3:0] act_en;
   logic       frame_err;
   logic [7:0] err_cnt;

   modport master (
      output rx_byte, rx_done, tx_busy,
      input  tx_byte, tx_start, act_addr, act_data, act_wr, act_en, frame_err, err_cnt
   );

   modport slave (
      input  rx_byte, rx_done, tx_busy,
      output tx_byte, tx_start, act_addr, act_data, act_wr, act_en, frame_err, err_cnt
   );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Framed UART command decoder driving a 4-channel actuator bank with ACK/NAK replies.
// Define UART_CMD_CSUM_EN for a 4-byte frame with a trailing XOR checksum.
module uart_cmd_ctrl #(
   parameter logic [15:0] TIMEOUT_CYC = 16'd1000,
   parameter logic [7:0]  HDR_BYTE    = 8'hA5
) (
   input logic            clk,
   input logic            rst,
   uart_cmd_ctrl_if.slave ctrl_io
);

   localparam logic [3:0] OpWrite  = 4'h1;
   localparam logic [3:0] OpEnable = 4'h2;
   localparam logic [7:0] RespAck  = 8'h06;
   localparam logic [7:0] RespNak  = 8'h15;

   typedef enum logic [2:0] {
      StIdle,
      StGetCmd,
      StGetData,
`ifdef UART_CMD_CSUM_EN
      StGetCsum,
`endif
      StExec,
      StResp
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] tmo_q, tmo_d, tmo_inc;
   logic [3:0]  opcode_q, opcode_d;
   logic [1:0]  chan_q, chan_d;
`ifdef UART_CMD_CSUM_EN
   logic [1:0]  cmd_mid_q, cmd_mid_d;
   logic [7:0]  data_q, data_d;
`endif
   logic [7:0]  tx_byte_q, tx_byte_d;
   logic [1:0]  act_addr_q, act_addr_d;
   logic [7:0]  act_data_q, act_data_d;
   logic        act_wr_q, act_wr_d;
   logic [3:0]  act_en_q, act_en_d;
   logic        frame_err_q, frame_err_d;
   logic [7:0]  err_cnt_q, err_cnt_d;

   logic        tx_start;
   logic        in_get;
   logic        fin;
   logic        err;
   logic [7:0]  fin_data;
   logic        csum_ok;

   // The frame is executed on the edge that latches its final byte, so the actuator
   // strobe, enable update and error pulse are all visible during the EXEC cycle.
`ifdef UART_CMD_CSUM_EN
   assign fin_data = data_q;
   assign csum_ok  = (ctrl_io.rx_byte == (HDR_BYTE ^ {opcode_q, cmd_mid_q, chan_q} ^ data_q));
`else
   assign fin_data = ctrl_io.rx_byte;
   assign csum_ok  = 1'b1;
`endif

   always_comb begin
      state_d     = state_q;
      tmo_d       = tmo_q;
      tmo_inc     = tmo_q + 16'd1;
      opcode_d    = opcode_q;
      chan_d      = chan_q;
`ifdef UART_CMD_CSUM_EN
      cmd_mid_d   = cmd_mid_q;
      data_d      = data_q;
`endif
      tx_byte_d   = tx_byte_q;
      act_addr_d  = act_addr_q;
      act_data_d  = act_data_q;
      act_wr_d    = 1'b0;
      act_en_d    = act_en_q;
      frame_err_d = 1'b0;
      err_cnt_d   = err_cnt_q;
      tx_start    = 1'b0;
      in_get      = 1'b0;
      fin         = 1'b0;
      err         = 1'b0;

      case (state_q)
         StIdle: begin
            tmo_d = '0;
            if (ctrl_io.rx_done && (ctrl_io.rx_byte == HDR_BYTE)) begin
               state_d = StGetCmd;
            end
         end
         StGetCmd: begin
            in_get = 1'b1;
            if (ctrl_io.rx_done) begin
               opcode_d  = ctrl_io.rx_byte[7:4];
               chan_d    = ctrl_io.rx_byte[1:0];
`ifdef UART_CMD_CSUM_EN
               cmd_mid_d = ctrl_io.rx_byte[3:2];
`endif
               state_d   = StGetData;
            end
         end
         StGetData: begin
            in_get = 1'b1;
            if (ctrl_io.rx_done) begin
`ifdef UART_CMD_CSUM_EN
               data_d  = ctrl_io.rx_byte;
               state_d = StGetCsum;
`else
               fin     = 1'b1;
               state_d = StExec;
`endif
            end
         end
`ifdef UART_CMD_CSUM_EN
         StGetCsum: begin
            in_get = 1'b1;
            if (ctrl_io.rx_done) begin
               fin     = 1'b1;
               state_d = StExec;
            end
         end
`endif
         StExec: begin
            state_d = StResp;
         end
         StResp: begin
            if (!ctrl_io.tx_busy) begin
               // Reset in this cycle must suppress the request, not just the next state.
               tx_start = !rst;
               state_d  = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (in_get) begin
         if (ctrl_io.rx_done) begin
            tmo_d = '0;
         end else if (tmo_inc >= TIMEOUT_CYC) begin
            tmo_d   = '0;
            err     = 1'b1;
            state_d = StIdle;
         end else begin
            tmo_d = tmo_inc;
         end
      end

      if (fin) begin
         tx_byte_d = RespAck;
         if (!csum_ok) begin
            tx_byte_d = RespNak;
            err       = 1'b1;
         end else if (opcode_q == OpWrite) begin
            act_wr_d   = 1'b1;
            act_addr_d = chan_q;
            act_data_d = fin_data;
         end else if (opcode_q == OpEnable) begin
            act_en_d[chan_q] = fin_data[0];
         end else begin
            tx_byte_d = RespNak;
            err       = 1'b1;
         end
      end

      if (err) begin
         frame_err_d = 1'b1;
         if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         tmo_q       <= '0;
         opcode_q    <= '0;
         chan_q      <= '0;
`ifdef UART_CMD_CSUM_EN
         cmd_mid_q   <= '0;
         data_q      <= '0;
`endif
         tx_byte_q   <= '0;
         act_addr_q  <= '0;
         act_data_q  <= '0;
         act_wr_q    <= 1'b0;
         act_en_q    <= '0;
         frame_err_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         tmo_q       <= tmo_d;
         opcode_q    <= opcode_d;
         chan_q      <= chan_d;
`ifdef UART_CMD_CSUM_EN
         cmd_mid_q   <= cmd_mid_d;
         data_q      <= data_d;
`endif
         tx_byte_q   <= tx_byte_d;
         act_addr_q  <= act_addr_d;
         act_data_q  <= act_data_d;
         act_wr_q    <= act_wr_d;
         act_en_q    <= act_en_d;
         frame_err_q <= frame_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign ctrl_io.tx_byte   = tx_byte_q;
   assign ctrl_io.tx_start  = tx_start;
   assign ctrl_io.act_addr  = act_addr_q;
   assign ctrl_io.act_data  = act_data_q;
   assign ctrl_io.act_wr    = act_wr_q;
   assign ctrl_io.act_en    = act_en_q;
   assign ctrl_io.frame_err = frame_err_q;
   assign ctrl_io.err_cnt   = err_cnt_q;

endmodule
